// File: rtl/vector_load_buffer.sv
// Packs a valid/ready element stream into N lanes and hands the vector to reduce_vector_alu.
// Optional macro ZERO_PAD_EN clears lanes beyond the current length when the vector launches.
module vector_load_buffer #(
  parameter int BITS = 8,
  parameter int N    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] s_data,
  input  logic            s_valid,
  input  logic            s_last,
  input  logic [1:0]      s_sel,
  output logic            s_ready,
  output logic [BITS-1:0] vec [N-1:0],
  output logic [7:0]      vec_len,
  output logic [1:0]      sel,
  output logic            set,
  output logic            en,
  input  logic            done,
  output logic            busy,
  output logic            ovf_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FILL   = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] LAUNCH = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;

  localparam logic [8:0] NCNT = 9'(N);

  logic [2:0]      r_state;
  logic [8:0]      r_count;
  logic [BITS-1:0] r_vec [N-1:0];
  logic [7:0]      r_vec_len;
  logic [1:0]      r_sel;
  logic            r_set;
  logic            r_en;
  logic            r_busy;
  logic            r_ovf;
  logic            r_ready;

  logic            w_acc;
  logic [2:0]      w_state_nxt;
  logic [8:0]      w_cnt_nxt;
  logic            w_wr;
  logic            w_launch;
  logic            w_done_ack;
  logic [8:0]      w_widx;

  assign w_acc = s_valid && r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_count;
    w_wr        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_wr        = 1'b1;
          w_cnt_nxt   = 9'd1;
          w_state_nxt = s_last ? LAUNCH : FILL;
        end
      end
      FILL: begin
        if (w_acc) begin
          w_wr      = 1'b1;
          w_cnt_nxt = r_count + 9'd1;
          if (s_last)                 w_state_nxt = LAUNCH;
          else if (w_cnt_nxt == NCNT) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_acc && s_last) w_state_nxt = LAUNCH;
      end
      LAUNCH: w_state_nxt = WAIT;
      WAIT: begin
        if (done) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 9'd0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // LAUNCH is only ever entered from an accepted s_last beat
  assign w_launch   = (w_state_nxt == LAUNCH);
  assign w_done_ack = (r_state == WAIT) && done;
  assign w_widx     = (r_state == IDLE) ? 9'd0 : r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_count   <= 9'd0;
      r_vec_len <= 8'd0;
      r_sel     <= 2'd0;
      r_set     <= 1'b0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_cnt_nxt;
      r_ready <= (w_state_nxt == IDLE) || (w_state_nxt == FILL) || (w_state_nxt == DRAIN);
      r_set   <= w_launch;

      if (w_launch) begin
        r_sel     <= s_sel;
        r_vec_len <= 8'(w_cnt_nxt - 9'd1);
      end

      if (w_launch)        r_en <= 1'b1;
      else if (w_done_ack) r_en <= 1'b0;

      if (r_state == IDLE && w_acc) r_busy <= 1'b1;
      else if (w_done_ack)          r_busy <= 1'b0;

      if (r_state == IDLE && w_acc)
        r_ovf <= 1'b0;
      else if (r_state == FILL && w_acc && !s_last && w_cnt_nxt == NCNT)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_vec[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_wr && w_widx == 9'(i))
          r_vec[i] <= s_data;
`ifdef ZERO_PAD_EN
        else if (w_launch && 9'(i) >= w_cnt_nxt)
          r_vec[i] <= '0;
`endif
      end
    end
  end

  assign s_ready = r_ready;
  assign vec     = r_vec;
  assign vec_len = r_vec_len;
  assign sel     = r_sel;
  assign set     = r_set;
  assign en      = r_en;
  assign busy    = r_busy;
  assign ovf_err = r_ovf;

endmodule

// File: tb/tb_vector_load_buffer.sv
// Directed bench for vector_load_buffer (BITS=8, N=8); honours ZERO_PAD_EN when defined.
module tb_vector_load_buffer;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic [1:0] s_sel;
  logic       s_ready;
  logic [7:0] vec [7:0];
  logic [7:0] vec_len;
  logic [1:0] sel;
  logic       set;
  logic       en;
  logic       done;
  logic       busy;
  logic       ovf_err;

  int total = 0;
  int bad   = 0;

  vector_load_buffer #(.BITS(8), .N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_sel(s_sel),
    .s_ready(s_ready),
    .vec(vec), .vec_len(vec_len), .sel(sel), .set(set), .en(en),
    .done(done), .busy(busy), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic last, input logic [1:0] sl);
    s_data  = d;
    s_last  = last;
    s_sel   = sl;
    s_valid = 1'b1;
    chk("ready_at_beat", 32'(s_ready), 1);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic alu_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; s_sel = 2'd0; done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_set", 32'(set), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_vec_len", 32'(vec_len), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_lane0", 32'(vec[0]), 0);
    chk("rst_lane7", 32'(vec[7]), 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(s_ready), 1);

    // basic four-element vector
    beat(8'h04, 1'b0, 2'd3);
    beat(8'h40, 1'b0, 2'd3);
    beat(8'h12, 1'b0, 2'd3);
    chk("basic_no_early_set", 32'(set), 0);
    chk("basic_busy_fill", 32'(busy), 1);
    beat(8'h7F, 1'b1, 2'd3);
    chk("basic_set", 32'(set), 1);
    chk("basic_en", 32'(en), 1);
    chk("basic_vec_len", 32'(vec_len), 3);
    chk("basic_sel", 32'(sel), 3);
    chk("basic_ready_launch", 32'(s_ready), 0);
    chk("basic_lane0", 32'(vec[0]), 32'h04);
    chk("basic_lane1", 32'(vec[1]), 32'h40);
    chk("basic_lane2", 32'(vec[2]), 32'h12);
    chk("basic_lane3", 32'(vec[3]), 32'h7F);
    step();
    chk("basic_set_one_cycle", 32'(set), 0);
    chk("basic_en_wait", 32'(en), 1);
    chk("basic_ready_wait", 32'(s_ready), 0);
    s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1; s_sel = 2'd0;
    step();
    s_valid = 1'b0; s_last = 1'b0;
    chk("basic_blocked_lane0", 32'(vec[0]), 32'h04);
    chk("basic_blocked_sel", 32'(sel), 3);
    chk("basic_blocked_set", 32'(set), 0);
    chk("basic_blocked_busy", 32'(busy), 1);
    alu_done();
    chk("basic_done_busy", 32'(busy), 0);
    chk("basic_done_en", 32'(en), 0);
    chk("basic_done_ready", 32'(s_ready), 1);
    chk("basic_hold_len", 32'(vec_len), 3);
    chk("basic_hold_lane3", 32'(vec[3]), 32'h7F);

    // single element
    beat(8'h55, 1'b1, 2'd1);
    chk("single_set", 32'(set), 1);
    chk("single_vec_len", 32'(vec_len), 0);
    chk("single_lane0", 32'(vec[0]), 32'h55);
    chk("single_sel", 32'(sel), 1);
    step();
    chk("single_set_drop", 32'(set), 0);
    alu_done();
    chk("single_idle_busy", 32'(busy), 0);

    // overflow: ten beats into eight lanes
    for (int k = 1; k <= 10; k++) begin
      beat(8'(k), (k == 10), 2'd2);
      if (k == 8) begin
        chk("ovf_flag_at_8", 32'(ovf_err), 1);
        chk("ovf_drain_ready", 32'(s_ready), 1);
        chk("ovf_no_set", 32'(set), 0);
      end
    end
    chk("ovf_set", 32'(set), 1);
    chk("ovf_vec_len", 32'(vec_len), 7);
    chk("ovf_flag", 32'(ovf_err), 1);
    chk("ovf_sel", 32'(sel), 2);
    for (int i = 0; i < 8; i++) chk($sformatf("ovf_lane%0d", i), 32'(vec[i]), i + 1);
    step();
    alu_done();
    chk("ovf_sticky", 32'(ovf_err), 1);
    chk("ovf_idle_busy", 32'(busy), 0);

    // done asserted outside WAIT is ignored
    beat(8'h10, 1'b0, 2'd0);
    chk("ovf_cleared", 32'(ovf_err), 0);
    done = 1'b1;
    step();
    chk("done_fill_busy", 32'(busy), 1);
    chk("done_fill_ready", 32'(s_ready), 1);
    chk("done_fill_set", 32'(set), 0);
    beat(8'h20, 1'b1, 2'd1);
    chk("done_launch_set", 32'(set), 1);
    chk("done_launch_len", 32'(vec_len), 1);
    step();
    chk("done_launch_en", 32'(en), 1);
    chk("done_launch_busy", 32'(busy), 1);
    chk("done_launch_set_drop", 32'(set), 0);
    step();
    chk("done_wait_busy", 32'(busy), 0);
    chk("done_wait_en", 32'(en), 0);
    step();
    step();
    chk("done_held_set", 32'(set), 0);
    chk("done_held_busy", 32'(busy), 0);
    chk("done_held_en", 32'(en), 0);
    chk("done_held_ready", 32'(s_ready), 1);
    done = 1'b0;
    chk("done_lane0", 32'(vec[0]), 32'h10);
    chk("done_lane1", 32'(vec[1]), 32'h20);

    // asynchronous reset in the middle of a fill
    beat(8'hA1, 1'b0, 2'd0);
    beat(8'hA2, 1'b0, 2'd0);
    beat(8'hA3, 1'b0, 2'd0);
    chk("mid_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_set", 32'(set), 0);
    chk("mid_rst_en", 32'(en), 0);
    chk("mid_rst_vec_len", 32'(vec_len), 0);
    chk("mid_rst_lane0", 32'(vec[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("mid_ready_after", 32'(s_ready), 1);
    beat(8'h0B, 1'b0, 2'd0);
    beat(8'h0C, 1'b1, 2'd0);
    chk("mid_next_set", 32'(set), 1);
    chk("mid_next_len", 32'(vec_len), 1);
    chk("mid_next_lane0", 32'(vec[0]), 32'h0B);
    chk("mid_next_lane1", 32'(vec[1]), 32'h0C);
    step();
    alu_done();

    // stale lanes after a shorter vector
    for (int k = 0; k < 8; k++) beat(8'hFF, (k == 7), 2'd0);
    chk("full_len", 32'(vec_len), 7);
    chk("full_no_ovf", 32'(ovf_err), 0);
    step();
    alu_done();
    beat(8'h01, 1'b0, 2'd0);
    beat(8'h02, 1'b1, 2'd0);
    chk("pad_len", 32'(vec_len), 1);
    chk("pad_lane0", 32'(vec[0]), 32'h01);
    chk("pad_lane1", 32'(vec[1]), 32'h02);
    for (int i = 2; i < 8; i++) begin
`ifdef ZERO_PAD_EN
      chk($sformatf("pad_lane%0d", i), 32'(vec[i]), 0);
`else
      chk($sformatf("pad_lane%0d", i), 32'(vec[i]), 32'hFF);
`endif
    end
    step();
    alu_done();
    chk("end_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_load_buffer.md
Name: vector_load_buffer

Overview:
- Upstream feeder for reduce_vector_alu.
- Accepts vector elements one per cycle over a valid/ready stream from the host interface and packs them into an N-lane register array.
- On end of vector, presents the lanes, the last-index length and the op select to the reduction ALU, then pulses its start strobe.
- Holds everything stable until the ALU reports done, then frees itself for the next vector.

Parameters:
- BITS, 8, element width in bits
- N, 8, number of lanes (max vector length); 2..255

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_data  in  BITS  incoming element
- s_valid  in  1  s_data valid
- s_last  in  1  marks final element of the vector
- s_sel  in  2  reduction op; sampled with the accepted s_last beat
- s_ready  out  1  buffer can accept an element this cycle
- vec  out  BITS x N (unpacked [N-1:0])  lane array to ALU `in`
- vec_len  out  8  index of last valid lane (count-1) to ALU `in_len`
- sel  out  2  op select to ALU `sel`
- set  out  1  one-cycle start strobe to ALU `set`
- en  out  1  ALU enable
- done  in  1  ALU done
- busy  out  1  high from first accepted beat until ALU done consumed
- ovf_err  out  1  sticky; vector exceeded N elements

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, count=0, all vec lanes=0, vec_len=0, sel=0, set=0, en=0, busy=0, ovf_err=0.
  - s_ready=1 one cycle after deassertion.
- Transfer: a beat is accepted when s_valid && s_ready at a clock edge. s_ready is high only in IDLE, FILL and DRAIN.
- IDLE:
  - Accepted beat writes lane 0, count=1, busy=1, ovf_err cleared.
  - If s_last is also set: sel<=s_sel, go LAUNCH; else go FILL.
- FILL:
  - Accepted beat writes lane[count], count++.
  - If s_last: latch sel, go LAUNCH.
  - Else if count becomes N: set ovf_err, go DRAIN.
- DRAIN:
  - Accepts and discards beats.
  - The s_last beat latches sel and goes to LAUNCH; lanes are unchanged.
- LAUNCH (exactly 1 cycle):
  - set=1, en=1, vec_len=count-1; s_ready=0.
  - Next state WAIT.
- WAIT:
  - set=0, en=1; vec, vec_len and sel are held.
  - When done=1: count=0, busy=0, en=0, go IDLE.
  - done is ignored in every state except WAIT.
- Latency: set rises on the clock edge following acceptance of the last beat (1 cycle).
- vec, vec_len and sel must not change from LAUNCH until the done edge.
- Simultaneous events:
  - In IDLE, a single beat with s_last produces a 1-element vector: vec_len=0.
  - A beat offered while s_ready=0 is not consumed; the source holds it.
- Reset mid-operation, in any state: immediately return to reset values. A partially filled vector is lost, and an in-flight ALU op is abandoned (en drops).
- Widths: count is 9 bits internally; vec_len is the low 8 bits of count-1.

Optional Feature:
- Macro ZERO_PAD_EN.
- Defined: on entry to LAUNCH, lanes with index >= count are cleared to 0, so the ALU never sees stale data from a previous longer vector.
- Undefined: unused lanes keep whatever was last written (or reset 0), which saves N*BITS clears. The ALU relies on vec_len alone.

Test Plan:
- Basic: beats 0x04,0x40,0x12,0x7F with s_last on the 4th, s_sel=3 -> lane[0..3]=04,40,12,7F, vec_len=3, sel=3, set high exactly 1 cycle after the 4th accept, s_ready=0 until done pulse, then busy=0 and s_ready=1.
- Single element: 0x55 with s_last in IDLE, s_sel=1 -> vec_len=0, lane0=0x55, set pulse next cycle.
- Overflow (N=8): 10 beats 1..10, last on the 10th -> lanes hold 1..8, vec_len=7, ovf_err=1, beats 9 and 10 consumed with s_ready=1 and discarded; ovf_err clears on the next vector's first beat.
- Backpressure/done ordering: drive done=1 during FILL and during LAUNCH -> ignored; done held 3 cycles in WAIT -> only one return to IDLE, no second set.
- Reset mid-fill: 3 beats accepted, pull rst_n low asynchronously between edges -> busy/set/en/vec_len drop to 0 without a clock; next vector of 2 beats launches with vec_len=1.
- ZERO_PAD_EN: load 8 beats of 0xFF, complete, then load a 2-beat vector 0x01,0x02 -> with macro, lanes[2..7]=0; without, lanes[2..7]=0xFF.
